demux8_reg: RTL and testbench
=============================

// Module: demux8_reg
// PURPOSE
//  - Registered 1-to-8 distributor: the write-side counterpart of the 8:1 read mux.
//  - Steers one WIDTH-bit bus into one of eight holding registers, selected by a 3-bit select.
//  - Tracks per-slot valid and updated status.
//  - Sits on the datapath write-back side. The eight outputs feed the 8:1 mux inputs a0..a7.
// PARAMETERS
//  - WIDTH  8  data width of input bus and each holding register
// PORTS
//  - clk      in   1        rising-edge clock (single clock domain)
//  - rst      in   1        synchronous active-high reset
//  - d        in   WIDTH    write data
//  - s        in   3        destination slot select (0..7)
//  - we       in   1        write enable; sampled on rising edge of clk
//  - clr      in   1        synchronous clear of all slots and valid bits
//  - y0..y7   out  WIDTH    holding registers, one per slot
//  - vld      out  8        sticky per-slot valid; bit i = slot i written since last clr/rst
//  - upd      out  8        one-hot pulse; bit i high for one cycle after slot i is written
//  - ptr      out  3        auto-increment pointer (present only with DEMUX8_AUTOINC_EN)
//  - inc_mode in   1        1 = use ptr instead of s (present only with DEMUX8_AUTOINC_EN)
// BEHAVIOUR
//  - Reset (rst=1 at edge): y0..y7=0, vld=0, upd=0, ptr=0. rst overrides we and clr.
//  - Write latency is 1 cycle:
//    - we=1 at edge k with dest=n: y<n> = d visible after edge k.
//    - Also after edge k: vld[n]=1, upd = 8'b1 << n.
//  - Cycles without a write: upd=0 after the next edge. upd is never high for two edges
//    unless writes occur back-to-back.
//  - Back-to-back writes: every cycle accepted, no stall. There is no ready signal.
//    - Same slot twice: last value wins.
//    - upd follows each write.
//  - Only the selected slot changes on a write. All other y/vld hold.
//  - clr=1, we=0: all y=0, vld=0, upd=0 after the edge.
//  - clr=1 and we=1 in the same cycle:
//    - Clear applies first, then the write.
//    - Result: only slot n holds d, vld = 1<<n, upd = 1<<n.
//  - s is a full 3-bit decode. All 8 codes are valid, so no out-of-range case exists.
//  - Outputs are driven only from registers. There is no combinational path from d/s/we
//    to any output.
//  - dest = s when the macro is absent or inc_mode=0; dest = ptr otherwise.
// CONFIGURATION
//  - Macro DEMUX8_AUTOINC_EN.
//  - Defined:
//    - Ports inc_mode and ptr exist.
//    - A 3-bit pointer register drives dest when inc_mode=1.
//    - ptr increments by 1 on each accepted write with inc_mode=1 and wraps 7 -> 0.
//    - ptr resets to 0 on rst or clr. If clr and we occur together: the write goes to
//      slot 0 and ptr=1 afterwards.
//    - Writes with inc_mode=0 use s and leave ptr unchanged.
//  - Undefined:
//    - Neither port exists and no pointer logic is present.
//    - dest is always s.
// TESTING
//  - Reset: drive d=8'hFF, we=1, rst=1 for 2 cycles -> all y=0, vld=0, upd=0 (ptr=0).
//  - Sweep: write d=8'h10+i to s=i for i=0..7 on consecutive cycles:
//    - Each upd = 1<<i one cycle after its write.
//    - Final y<i> = 8'h10+i and vld=8'hFF.
//  - Overwrite and hold:
//    - Write 8'hA5 to s=3, then 8'h5A to s=3 -> y3=8'h5A, vld[3]=1.
//    - Other slots unchanged; upd=8'h08 on both cycles, then 0.
//  - Clear with write: vld=8'hFF, then clr=1, we=1, s=6, d=8'h3C in the same cycle:
//    - y6=8'h3C, all other y=0.
//    - vld=8'h40, upd=8'h40.
//  - Mid-stream reset: rst=1 in the same cycle as we=1, s=2, d=8'h77 -> y2=0, vld=0, upd=0.
//  - AUTOINC (macro defined): inc_mode=1, 9 writes d=1..9, s=0 held:
//    - y0..y7 = 9,2,3,4,5,6,7,8.
//    - ptr=1 at end (wrap verified); s ignored.

Source files
------------

// File: rtl/demux8_reg.sv
// Registered 1-to-8 distributor: one write bus steered into eight holding registers
// with per-slot valid/update status. Optional auto-increment pointer: DEMUX8_AUTOINC_EN.
module demux8_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    input  logic [2:0]       s,
    input  logic             we,
    input  logic             clr,
`ifdef DEMUX8_AUTOINC_EN
    input  logic             inc_mode,
    output logic [2:0]       ptr,
`endif
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] y4,
    output logic [WIDTH-1:0] y5,
    output logic [WIDTH-1:0] y6,
    output logic [WIDTH-1:0] y7,
    output logic [7:0]       vld,
    output logic [7:0]       upd
);

    logic [WIDTH-1:0] slot_r [8];
    logic [7:0]       vld_r;
    logic [7:0]       upd_r;
    logic [2:0]       dest_s;
    logic [7:0]       wr_mask_s;

`ifdef DEMUX8_AUTOINC_EN
    logic [2:0]       ptr_r;
    logic [2:0]       ptr_nxt_s;

    // Destination select and next pointer; a clear resets the pointer before the write uses it.
    always_comb begin
        dest_s    = s;
        ptr_nxt_s = ptr_r;
        if (inc_mode) begin
            dest_s = clr ? 3'd0 : ptr_r;
        end else begin
            dest_s = s;
        end
        if (clr) begin
            ptr_nxt_s = (we && inc_mode) ? 3'd1 : 3'd0;
        end else if (we && inc_mode) begin
            ptr_nxt_s = ptr_r + 3'd1;
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 3'd0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign ptr = ptr_r;
`else
    // Destination is always the explicit select.
    always_comb begin
        dest_s = s;
    end
`endif

    // One-hot write strobe for the destination slot.
    always_comb begin
        wr_mask_s = 8'h00;
        if (we) begin
            wr_mask_s = 8'h01 << dest_s;
        end else begin
            wr_mask_s = 8'h00;
        end
    end

    // Holding registers and status; the write wins over the clear on its own slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                slot_r[i] <= '0;
            end
            vld_r <= 8'h00;
            upd_r <= 8'h00;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_mask_s[i]) begin
                    slot_r[i] <= d;
                end else if (clr) begin
                    slot_r[i] <= '0;
                end else begin
                    slot_r[i] <= slot_r[i];
                end
            end
            vld_r <= (clr ? 8'h00 : vld_r) | wr_mask_s;
            upd_r <= wr_mask_s;
        end
    end

    assign y0  = slot_r[0];
    assign y1  = slot_r[1];
    assign y2  = slot_r[2];
    assign y3  = slot_r[3];
    assign y4  = slot_r[4];
    assign y5  = slot_r[5];
    assign y6  = slot_r[6];
    assign y7  = slot_r[7];
    assign vld = vld_r;
    assign upd = upd_r;

endmodule

// File: tb/tb_demux8_reg.sv
// Table-driven bench for demux8_reg; auto-increment sequence runs when DEMUX8_AUTOINC_EN is defined.
module tb_demux8_reg;

    logic       clk;
    logic       rst;
    logic [7:0] d;
    logic [2:0] s;
    logic       we;
    logic       clr;
    logic [7:0] y0, y1, y2, y3, y4, y5, y6, y7;
    logic [7:0] vld;
    logic [7:0] upd;
`ifdef DEMUX8_AUTOINC_EN
    logic       inc_mode;
    logic [2:0] ptr;
`endif

    int n_tests;
    int n_fail;

    demux8_reg #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .d(d), .s(s), .we(we), .clr(clr),
`ifdef DEMUX8_AUTOINC_EN
        .inc_mode(inc_mode), .ptr(ptr),
`endif
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
        .vld(vld), .upd(upd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        clr;
        logic        we;
        logic [2:0]  s;
        logic [7:0]  d;
        logic [63:0] exp_y;   // {y7..y0}
        logic [7:0]  exp_vld;
        logic [7:0]  exp_upd;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic r, input logic c, input logic w, input logic [2:0] sel,
                                input logic [7:0] dat, input logic [63:0] ey,
                                input logic [7:0] ev, input logic [7:0] eu);
        vec_t v;
        v.rst = r; v.clr = c; v.we = w; v.s = sel; v.d = dat;
        v.exp_y = ey; v.exp_vld = ev; v.exp_upd = eu;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] ey, input logic [7:0] ev,
                             input logic [7:0] eu);
        check({tag, " y"},   {y7, y6, y5, y4, y3, y2, y1, y0}, ey);
        check({tag, " vld"}, {56'd0, vld}, {56'd0, ev});
        check({tag, " upd"}, {56'd0, upd}, {56'd0, eu});
    endtask

    // Drive inputs just after an edge, then sample just after the next edge.
    task automatic step(input logic r, input logic c, input logic w, input logic [2:0] sel,
                        input logic [7:0] dat);
        rst = r; clr = c; we = w; s = sel; d = dat;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0; clr = 1'b0; we = 1'b0; s = 3'd0; d = 8'h00;
`ifdef DEMUX8_AUTOINC_EN
        inc_mode = 1'b0;
`endif
        // Sweep
        vecs[0]  = mk(1'b0, 1'b0, 1'b1, 3'd0, 8'h10, 64'h0000_0000_0000_0010, 8'h01, 8'h01);
        vecs[1]  = mk(1'b0, 1'b0, 1'b1, 3'd1, 8'h11, 64'h0000_0000_0000_1110, 8'h03, 8'h02);
        vecs[2]  = mk(1'b0, 1'b0, 1'b1, 3'd2, 8'h12, 64'h0000_0000_0012_1110, 8'h07, 8'h04);
        vecs[3]  = mk(1'b0, 1'b0, 1'b1, 3'd3, 8'h13, 64'h0000_0000_1312_1110, 8'h0F, 8'h08);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 3'd4, 8'h14, 64'h0000_0014_1312_1110, 8'h1F, 8'h10);
        vecs[5]  = mk(1'b0, 1'b0, 1'b1, 3'd5, 8'h15, 64'h0000_1514_1312_1110, 8'h3F, 8'h20);
        vecs[6]  = mk(1'b0, 1'b0, 1'b1, 3'd6, 8'h16, 64'h0016_1514_1312_1110, 8'h7F, 8'h40);
        vecs[7]  = mk(1'b0, 1'b0, 1'b1, 3'd7, 8'h17, 64'h1716_1514_1312_1110, 8'hFF, 8'h80);
        vecs[8]  = mk(1'b0, 1'b0, 1'b0, 3'd2, 8'hEE, 64'h1716_1514_1312_1110, 8'hFF, 8'h00);
        // Overwrite and hold
        vecs[9]  = mk(1'b0, 1'b0, 1'b1, 3'd3, 8'hA5, 64'h1716_1514_A512_1110, 8'hFF, 8'h08);
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 3'd3, 8'h5A, 64'h1716_1514_5A12_1110, 8'hFF, 8'h08);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 3'd3, 8'h99, 64'h1716_1514_5A12_1110, 8'hFF, 8'h00);
        // Clear with write, then write, then plain clear
        vecs[12] = mk(1'b0, 1'b1, 1'b1, 3'd6, 8'h3C, 64'h003C_0000_0000_0000, 8'h40, 8'h40);
        vecs[13] = mk(1'b0, 1'b0, 1'b1, 3'd2, 8'h11, 64'h003C_0000_0011_0000, 8'h44, 8'h04);
        vecs[14] = mk(1'b0, 1'b1, 1'b0, 3'd2, 8'h22, 64'h0000_0000_0000_0000, 8'h00, 8'h00);
        vecs[15] = mk(1'b0, 1'b0, 1'b1, 3'd7, 8'h81, 64'h8100_0000_0000_0000, 8'h80, 8'h80);
        // Mid-stream reset beats a write
        vecs[16] = mk(1'b1, 1'b0, 1'b1, 3'd2, 8'h77, 64'h0000_0000_0000_0000, 8'h00, 8'h00);
        vecs[17] = mk(1'b0, 1'b0, 1'b0, 3'd2, 8'h77, 64'h0000_0000_0000_0000, 8'h00, 8'h00);

        // Reset held 2 cycles with a write pending
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b1, 3'd5, 8'hFF);
        step(1'b1, 1'b0, 1'b1, 3'd5, 8'hFF);
        check_all("reset", 64'd0, 8'h00, 8'h00);
`ifdef DEMUX8_AUTOINC_EN
        check("reset ptr", {61'd0, ptr}, 64'd0);
`endif

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].we, vecs[i].s, vecs[i].d);
            check_all($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_vld, vecs[i].exp_upd);
`ifdef DEMUX8_AUTOINC_EN
            check($sformatf("vec%0d ptr", i), {61'd0, ptr}, 64'd0);
`endif
        end

`ifdef DEMUX8_AUTOINC_EN
        // Nine pointer-driven writes with s held at 0; ninth wraps onto slot 0
        inc_mode = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0, 1'b1, 3'd0, 8'(k));
        end
        check_all("autoinc", 64'h0807_0605_0403_0209, 8'hFF, 8'h01);
        check("autoinc ptr", {61'd0, ptr}, 64'd1);
        // Clear with pointer write lands in slot 0, pointer becomes 1
        step(1'b0, 1'b1, 1'b1, 3'd4, 8'hAA);
        check_all("autoinc clr", 64'h0000_0000_0000_00AA, 8'h01, 8'h01);
        check("autoinc clr ptr", {61'd0, ptr}, 64'd1);
        // Explicit-select write leaves pointer alone
        inc_mode = 1'b0;
        step(1'b0, 1'b0, 1'b1, 3'd5, 8'h55);
        check_all("explicit", 64'h0000_5500_0000_00AA, 8'h21, 8'h20);
        check("explicit ptr", {61'd0, ptr}, 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
